// File: rtl/debounce_edge_detect.sv
// ---------------------------------------------------------------------------
// debounce_edge_detect
//
// Purpose:
//   Brings a raw asynchronous level (switch, external pin) into the clk
//   domain. The level is debounced by requiring DB_CYCLES consecutive
//   agreeing samples, and single-cycle pulses are emitted on each accepted
//   rising or falling change. Level changes that do not hold long enough are
//   rejected and tallied in a saturating glitch counter.
//
// Parameters:
//   SYNC_STAGES  number of synchronizer flops on din (2..4)
//   DB_CYCLES    consecutive agreeing samples needed to accept a level
//                (2..65535)
//
// Ports:
//   clk         single clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   din         raw asynchronous input level
//   dout        debounced, registered stable level
//   rise        one-cycle pulse when dout goes 0 -> 1
//   fall        one-cycle pulse when dout goes 1 -> 0
//   busy        high while a level change is being qualified
//   glitch_cnt  saturating count of rejected level changes
// ---------------------------------------------------------------------------
module debounce_edge_detect #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic       dout,
    output logic       rise,
    output logic       fall,
    output logic       busy,
    output logic [7:0] glitch_cnt
);

    // Qualification counter only has to reach DB_CYCLES-1.
    localparam int CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] S_LOW    = 2'd0;
    localparam logic [1:0] CHK_HIGH = 2'd1;
    localparam logic [1:0] S_HIGH   = 2'd2;
    localparam logic [1:0] CHK_LOW  = 2'd3;

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_in;

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             dout_nx;
    logic             rise_nx;
    logic             fall_nx;
    logic             glitch_hit;

    // Synchronizer chain; only the last stage is seen by the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], din};
        end
    end

    assign sync_in = sync_ff[SYNC_STAGES-1];

    // The first agreeing sample is counted on entry to a CHK state, so the
    // acceptance lands DB_CYCLES edges after sync_in changes. A return of
    // sync_in is checked before the terminal count, so a change that drops
    // out on the last qualifying cycle is still a glitch.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        dout_nx    = dout;
        rise_nx    = 1'b0;
        fall_nx    = 1'b0;
        glitch_hit = 1'b0;
        case (state)
            S_LOW: begin
                if (sync_in) begin
                    state_nx = CHK_HIGH;
                    cnt_nx   = CNT_ONE;
                end else begin
                    cnt_nx = '0;
                end
            end
            CHK_HIGH: begin
                if (!sync_in) begin
                    state_nx   = S_LOW;
                    cnt_nx     = '0;
                    glitch_hit = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_nx = S_HIGH;
                    cnt_nx   = '0;
                    dout_nx  = 1'b1;
                    rise_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!sync_in) begin
                    state_nx = CHK_LOW;
                    cnt_nx   = CNT_ONE;
                end else begin
                    cnt_nx = '0;
                end
            end
            CHK_LOW: begin
                if (sync_in) begin
                    state_nx   = S_HIGH;
                    cnt_nx     = '0;
                    glitch_hit = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_nx = S_LOW;
                    cnt_nx   = '0;
                    dout_nx  = 1'b0;
                    fall_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nx = S_LOW;
                cnt_nx   = '0;
            end
        endcase
    end

    // State, outputs and the saturating glitch tally; reset wins over any
    // acceptance due on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_LOW;
            cnt        <= '0;
            dout       <= 1'b0;
            rise       <= 1'b0;
            fall       <= 1'b0;
            glitch_cnt <= 8'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            dout  <= dout_nx;
            rise  <= rise_nx;
            fall  <= fall_nx;
            if (glitch_hit && (glitch_cnt != 8'hFF)) begin
                glitch_cnt <= glitch_cnt + 8'd1;
            end
        end
    end

    assign busy = (state == CHK_HIGH) || (state == CHK_LOW);

endmodule

// File: doc/debounce_edge_detect.md
DEBOUNCE_EDGE_DETECT -- requirements
Module: debounce_edge_detect

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the number of synchronizer flops on din; legal values are 2 to 4.
REQ-002 Parameter DB_CYCLES, default 4, SHALL set the number of consecutive agreeing synchronized samples required to accept a new level; legal values are 2 to 65535.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port din, input, 1 bit: raw asynchronous level, e.g. a switch or external pin.
REQ-006 Port dout, output, 1 bit: debounced stable level, registered; feeds the downstream d input of the capture flop.
REQ-007 Port rise, output, 1 bit: single-cycle pulse when dout goes 0 to 1.
REQ-008 Port fall, output, 1 bit: single-cycle pulse when dout goes 1 to 0.
REQ-009 Port busy, output, 1 bit: high while a level change is being qualified.
REQ-010 Port glitch_cnt, output, 8 bits: saturating count of rejected level changes.

Function
REQ-011 din SHALL pass through a chain of SYNC_STAGES flops; the last stage output (sync_in) is the only din-derived signal used by the FSM.
REQ-012 The FSM SHALL have exactly four states: S_LOW, CHK_HIGH, S_HIGH, CHK_LOW.
REQ-013 The internal counter cnt SHALL be ceil(log2(DB_CYCLES)) bits wide, minimum 1 bit, and SHALL never exceed DB_CYCLES-1.
REQ-014 S_LOW: if sync_in=1, go to CHK_HIGH with cnt=1; otherwise stay, cnt=0.
REQ-015 CHK_HIGH: if sync_in=0, go to S_LOW, cnt=0, and glitch_cnt+1; else if cnt=DB_CYCLES-1, go to S_HIGH, dout=1, rise=1, cnt=0; else cnt+1.
REQ-016 S_HIGH and CHK_LOW SHALL mirror REQ-014 and REQ-015 with levels inverted; acceptance SHALL set dout=0 and fall=1.
REQ-017 Latency: a din level held stable SHALL appear on dout exactly SYNC_STAGES+DB_CYCLES rising edges after the first edge that samples it.
REQ-018 rise and fall SHALL be registered, high for exactly one cycle, never high together, and coincident with the cycle in which dout first shows the new level.
REQ-019 busy SHALL be 1 exactly when the state is CHK_HIGH or CHK_LOW.
REQ-020 A pulse on sync_in shorter than DB_CYCLES cycles SHALL leave dout, rise and fall unchanged and SHALL increment glitch_cnt by 1.
REQ-021 glitch_cnt SHALL saturate at 255 and SHALL NOT wrap.
REQ-022 A sync_in return during the final qualifying cycle (cnt=DB_CYCLES-1) SHALL count as a glitch, not an acceptance.
REQ-023 dout SHALL change only on acceptance and SHALL NOT be driven combinationally from din.

Reset
REQ-024 When rst=1 at a rising clk edge, all synchronizer flops, dout, rise, fall, busy, cnt and glitch_cnt SHALL go to 0, and the state SHALL go to S_LOW.
REQ-025 rst SHALL take priority over every transition, including an acceptance in the same cycle; no rise or fall pulse SHALL be emitted on the cycle after reset.
REQ-026 Reset SHALL have no asynchronous path; with clk stopped, asserting rst SHALL change no output.
REQ-027 After rst deasserts with din=1, the block SHALL qualify the 1 as a normal rising change: rise after SYNC_STAGES+DB_CYCLES edges.

Verification (defaults: SYNC_STAGES=2, DB_CYCLES=4)
REQ-028 Clean rise: rst for 2 cycles, then din 0->1 held -> dout=1 and rise=1 for one cycle at the 6th edge after the change; busy=1 for edges 3-5.
REQ-029 Glitch: din high for 3 cycles then low -> dout stays 0, no rise, glitch_cnt=1; a 1-cycle din pulse also gives glitch_cnt+1.
REQ-030 Clean fall: from dout=1, drop din -> fall=1 for one cycle and dout=0 at the 6th edge; rise stays 0 throughout.
REQ-031 Reset mid-qualification: assert rst while in CHK_HIGH with cnt=3 -> next cycle dout=0, busy=0, cnt=0, glitch_cnt=0, no rise.
REQ-032 Saturation: inject 300 short pulses -> glitch_cnt reads 255, with no wrap to 0.
REQ-033 Bounce train: din toggles every cycle for 20 cycles, then settles at 1 -> exactly one rise pulse, dout=1 six edges after settling.
